// File: rtl/mem_access.sv
// mem_access: MEM-stage sequencer that issues loads/stores on the dreq/dresp data bus,
// stalls the pipeline while an access is outstanding and returns extended load data.
module mem_access #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              advance,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              busy,
  output logic              misalign,
  output logic [DATA_W-1:0] rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_rdata, w_shifted, w_ext;
  logic [2:0]        w_off;
  logic [7:0]        w_mask;
  logic              w_mem_op, w_start, w_active, w_done, w_is_store;
  assign w_off      = in_addr[2:0];
  assign w_mem_op   = in_valid & (in_load | in_store);
  assign w_is_store = in_store & ~in_load;
  assign misalign   = w_mem_op & (in_size == 2'd1 ? in_addr[0] :
                                  in_size == 2'd2 ? |in_addr[1:0] :
                                  in_size == 2'd3 ? |in_addr[2:0] : 1'b0);
  assign w_start    = w_mem_op & ~misalign;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // DONE holds off re-issue while the stage is frozen by some other hazard
  always_comb begin
    w_next = r_state == DONE ? (advance ? IDLE : DONE) :
             w_active        ? (dresp_data_ok ? (advance ? IDLE : DONE) : REQ) : IDLE;
  end
  always_comb begin
    w_active   = reset & ((r_state == IDLE & w_start) | r_state == REQ);
    w_done     = w_active & dresp_data_ok;
    dreq_valid = w_active;
    busy       = w_active & ~dresp_data_ok;
  end
  always_comb begin
    w_mask      = in_size == 2'd0 ? 8'h01 : in_size == 2'd1 ? 8'h03 : in_size == 2'd2 ? 8'h0F : 8'hFF;
    dreq_strobe = w_is_store ? w_mask << w_off : 8'h00;
    dreq_data   = w_is_store ? in_wdata << {w_off, 3'b000} : '0;
    w_shifted   = dresp_data >> {w_off, 3'b000};
    w_ext       = in_size == 2'd0 ? {{(DATA_W-8){~in_unsigned & w_shifted[7]}}, w_shifted[7:0]} :
                  in_size == 2'd1 ? {{(DATA_W-16){~in_unsigned & w_shifted[15]}}, w_shifted[15:0]} :
                  in_size == 2'd2 ? {{(DATA_W-32){~in_unsigned & w_shifted[31]}}, w_shifted[31:0]} :
                  w_shifted;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_rdata <= '0;
    else if (w_done) r_rdata <= w_ext;
  end
  assign dreq_addr = in_addr;
  assign dreq_size = in_size;
  assign rdata     = w_done ? w_ext : r_rdata;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for the memory-stage bus sequencer.
module tb_mem_access;
  logic        clk = 0, reset = 0;
  logic        in_valid = 0, in_load = 0, in_store = 0, in_unsigned = 0, advance = 1;
  logic [63:0] in_addr = 0, in_wdata = 0, dresp_data = 0;
  logic [1:0]  in_size = 0;
  logic        dresp_data_ok = 0;
  logic        dreq_valid, busy, misalign;
  logic [63:0] dreq_addr, dreq_data, rdata;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] sb_q[$];

  mem_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_addr(in_addr), .in_size(in_size), .in_unsigned(in_unsigned), .in_wdata(in_wdata),
    .advance(advance), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .busy(busy), .misalign(misalign), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // completed loads are compared against the scoreboard on the ok cycle
  always @(negedge clk) begin
    if (reset && dreq_valid && dresp_data_ok && in_load) begin
      if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("rdata", rdata, sb_q.pop_front());
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic st, input logic [63:0] a,
                        input logic [1:0] sz, input logic u, input logic [63:0] wd);
    in_valid = v; in_load = ld; in_store = st; in_addr = a; in_size = sz; in_unsigned = u; in_wdata = wd;
  endtask

  task automatic idle_op;
    set_op(0, 0, 0, 64'h0, 2'd0, 0, 64'h0);
    dresp_data_ok = 0; advance = 1;
  endtask

  initial begin
    @(negedge clk);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_misalign", misalign, 0);
    step; reset = 1;
    // 8B load, three wait cycles then completion
    step;
    set_op(1, 1, 0, 64'h80001000, 2'd3, 0, 0);
    advance = 0; dresp_data = 64'h1122334455667788;
    sb_q.push_back(64'h1122334455667788);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld8_busy", busy, 1);
      check("ld8_valid", dreq_valid, 1);
      check("ld8_addr", dreq_addr, 64'h80001000);
      check("ld8_strobe", dreq_strobe, 0);
      step;
    end
    dresp_data_ok = 1; advance = 1;
    @(negedge clk);
    check("ld8_busy_ok", busy, 0);
    step; idle_op;
    // 1B loads completing in the issue cycle, signed then unsigned
    for (int u = 0; u < 2; u++) begin
      set_op(1, 1, 0, 64'h80001003, 2'd0, u[0], 0);
      dresp_data = 64'h00000000_80000000; dresp_data_ok = 1;
      sb_q.push_back(u == 0 ? 64'hFFFFFFFFFFFFFF80 : 64'h80);
      @(negedge clk);
      check("ld1_busy", busy, 0);
      check("ld1_valid", dreq_valid, 1);
      step; idle_op;
    end
    // 2B store held until data_ok
    set_op(1, 0, 1, 64'h80002006, 2'd1, 0, 64'hABCD); advance = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st2_strobe", dreq_strobe, 8'hC0);
      check("st2_data", dreq_data, 64'hABCD000000000000);
      check("st2_busy", busy, i < 2);
      step;
      if (i == 1) begin dresp_data_ok = 1; advance = 1; end
    end
    idle_op;
    // stray data_ok while idle must be ignored
    dresp_data_ok = 1; advance = 0;
    @(negedge clk);
    check("stray_valid", dreq_valid, 0);
    step;
    dresp_data_ok = 0;
    set_op(1, 1, 0, 64'h80003000, 2'd3, 0, 0);
    @(negedge clk);
    check("stray_idle_busy", busy, 1);
    in_valid = 0; advance = 1;
    step;
    // 4B load completing under an external stall
    set_op(1, 1, 0, 64'h80003004, 2'd2, 0, 0);
    dresp_data = 64'hDEADBEEF_00000000; dresp_data_ok = 1; advance = 0;
    sb_q.push_back(64'hFFFFFFFFDEADBEEF);
    step; dresp_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", dreq_valid, 0);
      check("stall_busy", busy, 0);
      check("stall_rdata", rdata, 64'hFFFFFFFFDEADBEEF);
      if (i == 2) advance = 1;
      step;
    end
    @(negedge clk);
    check("stall_back_idle", dreq_valid, 1);
    in_valid = 0;
    step; idle_op;
    // misalignment cases and an aligned odd-byte access
    set_op(1, 1, 0, 64'h80000002, 2'd2, 0, 0);
    @(negedge clk);
    check("mis4_flag", misalign, 1);
    check("mis4_valid", dreq_valid, 0);
    check("mis4_busy", busy, 0);
    set_op(1, 0, 1, 64'h80000001, 2'd1, 0, 0);
    #1 check("mis2_flag", misalign, 1);
    set_op(1, 1, 0, 64'h80000004, 2'd3, 0, 0);
    #1 check("mis8_flag", misalign, 1);
    set_op(1, 1, 0, 64'h80000007, 2'd0, 0, 0);
    #1 check("al1_flag", misalign, 0);
    check("al1_valid", dreq_valid, 1);
    set_op(0, 1, 0, 64'h80000002, 2'd2, 0, 0);
    #1 check("bubble_misalign", misalign, 0);
    step; idle_op;
    // async reset while a request is outstanding
    set_op(1, 1, 0, 64'h80004000, 2'd3, 0, 0); advance = 0;
    step;
    #2 reset = 0;
    #1 check("arst_valid", dreq_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_rdata", rdata, 0);
    step; idle_op; reset = 1;
    @(negedge clk);
    check("post_rst_rdata", rdata, 0);
    set_op(1, 1, 0, 64'h80004000, 2'd3, 0, 0);
    #1 check("post_rst_idle", busy, 1);
    in_valid = 0;
    step;
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
